mem_port_arbiter: RTL and testbench

Shares one single-ported memory between the CPU's instruction-fetch path and its data-memory path. This lets the single-cycle datapath run against a unified memory that has wait states. Each requester has its own level-held request/valid handshake. The block holds one outstanding transaction at a time. When both requesters are pending it alternates between them, and it drives a request/acknowledge handshake toward the memory. It sits between the PC/instruction-memory and data-memory ports of the CPU and the unified memory model.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_watchdog.sv | 34 +++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    // Width of a counter that must be able to hold the value `limit` itself.
    function automatic int timeout_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Ack watchdog: counts BUSY cycles without mem_ack_i and flags the cycle in
// which the TIMEOUT-th such cycle occurs. Only built with MEM_ARB_TIMEOUT_EN.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = timeout_cnt_w(TIMEOUT);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

    // This cycle is the TIMEOUT-th one without ack when TIMEOUT-1 are already counted.
    assign expired = count_en && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch and data ports,
// one transaction at a time. Optional ack watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_valid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be at least 1");
    end

    state_t state;
    logic   last_dm;
    logic   if_elig;
    logic   dm_elig;
    logic   grant_dm;
    logic   grant_if;
    logic   timeout;

    // A requester still high during its own valid pulse is the finished
    // request, not a new one, so it is not eligible that cycle.
    // NOTE: every signal is fully assigned on each pass, so no latch is inferred.
    always_comb begin
        if_elig  = if_req_i && !if_valid_o;
        dm_elig  = dm_req_i && !dm_valid_o;
        grant_dm = dm_elig && (!if_elig || !last_dm);
        grant_if = if_elig && !grant_dm;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear    (state == IDLE),
        .count_en ((state != IDLE) && !mem_ack_i),
        .expired  (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_dm     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_valid_o  <= 1'b0;
            dm_valid_o  <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            if_valid_o <= 1'b0;
            dm_valid_o <= 1'b0;
            err_o      <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state       <= DM_BUSY;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                    end else if (grant_if) begin
                        state      <= IF_BUSY;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= if_addr_i;
                    end
                end

                IF_BUSY: begin
                    if (mem_ack_i || timeout) begin
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        last_dm    <= 1'b0;
                        if_valid_o <= 1'b1;
                        if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                        err_o      <= !mem_ack_i;
                    end
                end

                DM_BUSY: begin
                    if (mem_ack_i) begin
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        last_dm    <= 1'b1;
                        dm_valid_o <= 1'b1;
                        // Stores leave the last load value visible.
                        if (!mem_we_o) begin
                            dm_rdata_o <= mem_rdata_i;
                        end
                    end else if (timeout) begin
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        last_dm    <= 1'b1;
                        dm_valid_o <= 1'b1;
                        dm_rdata_o <= '0;
                        err_o      <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// cases and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_valid_o;
    logic [DW-1:0] if_rdata_o;
    logic          dm_req_i;
    logic          dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic          dm_valid_o;
    logic [DW-1:0] dm_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_ack_i;
    logic          err_o;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_valid_o  (if_valid_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_valid_o  (dm_valid_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .err_o       (err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] exp_rdata;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory contents as written through the DUT, and the bench's own view.
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    logic resp_en;
    logic rand_waits;
    logic force_ack;
    logic started;
    int   mem_wait;
    int   cur_wait;
    int   wcnt;

    // Random-run bookkeeping
    logic        if_pend, dm_pend, dm_cur_we;
    logic [31:0] if_exp, dm_exp, dm_hold;
    int          if_age, dm_age, n_if, n_dm, overlaps, spurious, stalls;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_val(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // One clock; outputs are then sampled 1 ns after the edge and the memory
    // responder updates its ack for the coming edge.
    task automatic step();
        @(posedge clk_i);
        #1;
        if (force_ack) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hBAD0_BAD0;
            force_ack   = 1'b0;
            started     = 1'b0;
        end else if (!resp_en || rst_i) begin
            mem_ack_i = 1'b0;
            started   = 1'b0;
        end else if (mem_req_o && !mem_ack_i) begin
            if (!started) begin
                started  = 1'b1;
                wcnt     = 0;
                cur_wait = rand_waits ? int'($urandom_range(0, 3)) : mem_wait;
            end
            if (wcnt == cur_wait) begin
                mem_ack_i = 1'b1;
                started   = 1'b0;
                if (mem_we_o) begin
                    mem[mem_addr_o] = mem_wdata_o;
                    mem_rdata_i     = $urandom();
                end else begin
                    mem_rdata_i = mem_read(mem_addr_o);
                end
            end else begin
                wcnt++;
            end
        end else begin
            mem_ack_i = 1'b0;
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int   lat;
        int   req_cycles;
        int   bad;
        logic got;
        mem_wait   = v.waits;
        lat        = 0;
        req_cycles = 0;
        bad        = 0;
        got        = 1'b0;
        if (v.is_dm) begin
            dm_we_i    = v.we;
            dm_addr_i  = v.addr;
            dm_wdata_i = v.wdata;
            dm_req_i   = 1'b1;
        end else begin
            if_addr_i = v.addr;
            if_req_i  = 1'b1;
        end
        while (!got && lat < 30) begin
            step();
            lat++;
            if (mem_req_o) begin
                req_cycles++;
                if (mem_addr_o !== v.addr || mem_we_o !== (v.is_dm & v.we) ||
                    (v.is_dm && v.we && mem_wdata_o !== v.wdata)) bad++;
            end
            got = v.is_dm ? dm_valid_o : if_valid_o;
        end
        check({tag, " valid seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, lat, 2 + v.waits);
        check({tag, " mem_req cycles"}, req_cycles, v.waits + 1);
        check({tag, " mem fields held"}, bad, 0);
        check({tag, " rdata"}, v.is_dm ? dm_rdata_o : if_rdata_o, v.exp_rdata);
        check({tag, " err_o"}, 32'(err_o), 32'd0);
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        step();
        check({tag, " idle after"}, 32'(mem_req_o), 32'd0);
    endtask

    task automatic rand_cycle(input logic allow_new);
        step();
        if (if_valid_o && dm_valid_o) overlaps++;
        if (if_valid_o) begin
            if (!if_pend) spurious++;
            else begin
                check("rand if rdata", if_rdata_o, if_exp);
                if_pend  = 1'b0;
                if_req_i = 1'b0;
                n_if++;
            end
        end
        if (dm_valid_o) begin
            if (!dm_pend) spurious++;
            else begin
                check("rand dm rdata", dm_rdata_o, dm_exp);
                if (!dm_cur_we) dm_hold = dm_exp;
                dm_pend  = 1'b0;
                dm_req_i = 1'b0;
                n_dm++;
            end
        end
        if (if_pend) if_age++;
        if (dm_pend) dm_age++;
        if (if_age > 40) begin stalls++; if_pend = 1'b0; if_req_i = 1'b0; if_age = 0; end
        if (dm_age > 40) begin stalls++; dm_pend = 1'b0; dm_req_i = 1'b0; dm_age = 0; end
        if (allow_new && !if_pend && $urandom_range(0, 2) == 0) begin
            if_addr_i = 32'($urandom_range(0, 63)) << 2;
            if_exp    = ref_read(if_addr_i);
            if_pend   = 1'b1;
            if_age    = 0;
            if_req_i  = 1'b1;
        end
        if (allow_new && !dm_pend && $urandom_range(0, 2) == 0) begin
            dm_addr_i  = 32'h100 + (32'($urandom_range(0, 15)) << 2);
            dm_cur_we  = 1'($urandom_range(0, 1));
            dm_we_i    = dm_cur_we;
            dm_wdata_i = $urandom();
            if (dm_cur_we) begin
                ref_mem[dm_addr_i] = dm_wdata_i;
                dm_exp = dm_hold;
            end else begin
                dm_exp = ref_read(dm_addr_i);
            end
            dm_pend  = 1'b1;
            dm_age   = 0;
            dm_req_i = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vecs [6];
        vec_t v;
        int   order [$];
        int   when  [$];
        int   cyc;
        int   ov;

        vecs[0] = '{1'b0, 1'b0, 32'h40, 32'h0,         0, 32'h2002_000A};
        vecs[1] = '{1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 3, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h10, 32'h0,         1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 32'h44, 32'h0,         2, 32'h0000_0013};
        vecs[4] = '{1'b1, 1'b1, 32'h14, 32'h1234_5678, 0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b0, 32'h14, 32'h0,         0, 32'h1234_5678};

        mem[32'h40] = 32'h2002_000A;
        mem[32'h44] = 32'h0000_0013;

        rst_i       = 1'b1;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        dm_req_i    = 1'b0;
        dm_we_i     = 1'b0;
        dm_addr_i   = '0;
        dm_wdata_i  = '0;
        mem_rdata_i = '0;
        mem_ack_i   = 1'b0;
        resp_en     = 1'b1;
        rand_waits  = 1'b0;
        force_ack   = 1'b0;
        started     = 1'b0;
        mem_wait    = 0;
        cur_wait    = 0;
        wcnt        = 0;

        step();
        step();
        check("reset mem_req_o", 32'(mem_req_o), 32'd0);
        check("reset mem_addr_o", mem_addr_o, 32'd0);
        check("reset mem_wdata_o", mem_wdata_o, 32'd0);
        check("reset valids", 32'({if_valid_o, dm_valid_o, err_o, mem_we_o}), 32'd0);
        check("reset if_rdata_o", if_rdata_o, 32'd0);
        check("reset dm_rdata_o", dm_rdata_o, 32'd0);
        rst_i = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Fetch held through its own valid cycle must not be granted again.
        mem_wait  = 0;
        if_addr_i = 32'h40;
        if_req_i  = 1'b1;
        step();
        step();
        check("noregrant valid", 32'(if_valid_o), 32'd1);
        step();
        check("noregrant mem_req (req held)", 32'(mem_req_o), 32'd0);
        if_req_i = 1'b0;
        step();
        check("noregrant mem_req (req low)", 32'(mem_req_o), 32'd0);
        check("noregrant no extra valid", 32'(if_valid_o), 32'd0);

        // Both requesters held from reset: dm, if, dm, if with one bubble each.
        rst_i     = 1'b1;
        if_addr_i = 32'h80;
        dm_addr_i = 32'h180;
        dm_we_i   = 1'b0;
        if_req_i  = 1'b1;
        dm_req_i  = 1'b1;
        step();
        rst_i = 1'b0;
        cyc   = 0;
        ov    = 0;
        while (order.size() < 4 && cyc < 40) begin
            step();
            cyc++;
            if (if_valid_o && dm_valid_o) ov++;
            if (dm_valid_o) begin
                order.push_back(0);
                when.push_back(cyc);
                check("contention dm rdata", dm_rdata_o, init_val(32'h180));
            end
            if (if_valid_o) begin
                order.push_back(1);
                when.push_back(cyc);
                check("contention if rdata", if_rdata_o, init_val(32'h80));
            end
        end
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        check("contention completions", order.size(), 4);
        check("contention valid overlap", ov, 0);
        for (int k = 0; k < order.size() && k < 4; k++) begin
            check($sformatf("contention grant %0d", k), order[k], k % 2);
            check($sformatf("contention cycle %0d", k), when[k], 2 * (k + 1));
        end
        step();
        check("contention idle after", 32'(mem_req_o), 32'd0);

        // Reset in DM_BUSY, then a late ack that must be ignored.
        resp_en   = 1'b0;
        dm_addr_i = 32'h184;
        dm_we_i   = 1'b0;
        dm_req_i  = 1'b1;
        step();
        step();
        check("midreset busy before", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1;
        step();
        check("midreset mem_req_o", 32'(mem_req_o), 32'd0);
        check("midreset mem_addr_o", mem_addr_o, 32'd0);
        check("midreset dm_rdata_o", dm_rdata_o, 32'd0);
        rst_i     = 1'b0;
        dm_req_i  = 1'b0;
        force_ack = 1'b1;
        step();
        step();
        check("late ack no valid", 32'({dm_valid_o, if_valid_o}), 32'd0);
        check("late ack mem_req_o", 32'(mem_req_o), 32'd0);
        check("late ack dm_rdata_o", dm_rdata_o, 32'd0);
        resp_en = 1'b1;
        v = '{1'b1, 1'b0, 32'h184, 32'h0, 1, init_val(32'h184)};
        run_vec("after reset", v);

        // Randomized traffic against the transaction-level model.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        mem.delete();
        ref_mem.delete();
        rand_waits = 1'b1;
        if_pend = 1'b0; dm_pend = 1'b0; dm_cur_we = 1'b0;
        if_exp = '0; dm_exp = '0; dm_hold = '0;
        if_age = 0; dm_age = 0; n_if = 0; n_dm = 0;
        overlaps = 0; spurious = 0; stalls = 0;
        for (int c = 0; c < 800; c++) rand_cycle(1'b1);
        for (int c = 0; c < 60 && (if_pend || dm_pend); c++) rand_cycle(1'b0);
        if (if_pend || dm_pend) stalls++;
        check("rand valid overlap", overlaps, 0);
        check("rand spurious valid", spurious, 0);
        check("rand stalled requests", stalls, 0);
        check("rand if traffic", 32'(n_if > 20), 32'd1);
        check("rand dm traffic", 32'(n_dm > 20), 32'd1);
        rand_waits = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        begin
            int   busy;
            logic seen;
            logic errv;
            logic [31:0] rd;
            busy      = 0;
            seen      = 1'b0;
            errv      = 1'b0;
            rd        = 32'hFFFF_FFFF;
            resp_en   = 1'b0;
            dm_we_i   = 1'b0;
            dm_addr_i = 32'h188;
            dm_req_i  = 1'b1;
            for (int c = 0; c < 20 && !seen; c++) begin
                step();
                if (mem_req_o) busy++;
                if (dm_valid_o) begin
                    seen = 1'b1;
                    errv = err_o;
                    rd   = dm_rdata_o;
                end
            end
            dm_req_i = 1'b0;
            check("timeout valid seen", 32'(seen), 32'd1);
            check("timeout busy cycles", busy, TO);
            check("timeout err_o", 32'(errv), 32'd1);
            check("timeout dm_rdata_o", rd, 32'd0);
            step();
            check("timeout err pulse ends", 32'(err_o), 32'd0);
            check("timeout idle", 32'(mem_req_o), 32'd0);
            resp_en = 1'b1;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
